cal_bus_sched: RTL and testbench

//  Schedules the shared data/addr/write bus between cal_cpu and cal_acc.

---
 rtl/cal_bus_sched.sv | 80 ++++++++
 tb/tb_cal_bus_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cal_bus_sched.sv
// Round-robin scheduler for the shared cal_cpu / cal_acc bus with a one-cycle
// turnaround between owners and a hold-time watchdog that raises yield requests.
module cal_bus_sched #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned PRIO_CPU = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             acc_req,
  output logic             cpu_gnt,
  output logic             acc_gnt,
  output logic             arb_res,
  output logic             cpu_yield,
  output logic             acc_yield,
  output logic             bus_idle,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_ACC, TURN} state_t;

  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic             LAST_RST = (PRIO_CPU != 0);

  state_t           state, state_nx;
  logic             last_acc, last_acc_nx;  // 1: ACC was the most recent owner
  logic [CNT_W-1:0] hold_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_acc <= LAST_RST;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      last_acc <= last_acc_nx;
      hold_cnt <= hold_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    last_acc_nx = last_acc;
    hold_nx     = '0;
    unique case (state)
      IDLE: begin
        if (cpu_req && acc_req) state_nx = last_acc ? GNT_CPU : GNT_ACC;
        else if (cpu_req)       state_nx = GNT_CPU;
        else if (acc_req)       state_nx = GNT_ACC;
      end
      GNT_CPU: if (!cpu_req) state_nx = acc_req ? TURN : IDLE;
      GNT_ACC: if (!acc_req) state_nx = cpu_req ? TURN : IDLE;
      TURN: begin
        // The turnaround only ever hands over to the side that did not own last.
        if (last_acc) state_nx = cpu_req ? GNT_CPU : IDLE;
        else          state_nx = acc_req ? GNT_ACC : IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (state_nx == GNT_CPU) last_acc_nx = 1'b0;
    if (state_nx == GNT_ACC) last_acc_nx = 1'b1;

    if (state_nx == GNT_CPU || state_nx == GNT_ACC) begin
      if (state_nx != state)      hold_nx = CNT_W'(1);
      else if (hold_cnt == CNT_SAT) hold_nx = hold_cnt;
      else                        hold_nx = hold_cnt + CNT_W'(1);
    end
  end

  assign cpu_gnt   = (state == GNT_CPU);
  assign acc_gnt   = (state == GNT_ACC);
  assign arb_res   = acc_gnt;
  assign bus_idle  = (state == IDLE);
  assign cpu_yield = cpu_gnt & acc_req & (hold_cnt >= HOLD_LIM);
  assign acc_yield = acc_gnt & cpu_req & (hold_cnt >= HOLD_LIM);

endmodule

// File: tb/tb_cal_bus_sched.sv
// Directed and randomized checks of cal_bus_sched against an ownership-level
// reference model of the bus schedule.
module tb_cal_bus_sched;

  localparam int unsigned MAX_HOLD = 16;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned PRIO_CPU = 1;
  localparam int          SAT      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cpu_req = 1'b0;
  logic             acc_req = 1'b0;
  logic             cpu_gnt, acc_gnt, arb_res, cpu_yield, acc_yield, bus_idle;
  logic [CNT_W-1:0] hold_cnt;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  // reference model: owner 0 = nobody, 1 = CPU, 2 = ACC
  int m_owner, m_hold, m_last;
  bit m_turn;

  cal_bus_sched #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W), .PRIO_CPU(PRIO_CPU)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .acc_req(acc_req),
    .cpu_gnt(cpu_gnt), .acc_gnt(acc_gnt), .arb_res(arb_res),
    .cpu_yield(cpu_yield), .acc_yield(acc_yield), .bus_idle(bus_idle),
    .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner = 0; m_turn = 1'b0; m_hold = 0;
    m_last  = (PRIO_CPU != 0) ? 2 : 1;
  endfunction

  function automatic void grant(input int who);
    m_owner = who; m_hold = 1; m_last = who;
  endfunction

  function automatic void model_step(input logic c, input logic a);
    bit want [3];
    want[0] = 1'b0; want[1] = c; want[2] = a;
    if (m_turn) begin
      m_turn = 1'b0;
      if (want[3 - m_last]) grant(3 - m_last);
    end else if (m_owner == 0) begin
      if (c && a)  grant(3 - m_last);
      else if (c)  grant(1);
      else if (a)  grant(2);
    end else if (want[m_owner]) begin
      m_hold = (m_hold + 1 > SAT) ? SAT : m_hold + 1;
    end else begin
      m_turn  = want[3 - m_owner];
      m_owner = 0;
      m_hold  = 0;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic eg_cpu, eg_acc;
    eg_cpu = (m_owner == 1);
    eg_acc = (m_owner == 2);
    check("cpu_gnt",   32'(cpu_gnt),   32'(eg_cpu));
    check("acc_gnt",   32'(acc_gnt),   32'(eg_acc));
    check("arb_res",   32'(arb_res),   32'(eg_acc));
    check("bus_idle",  32'(bus_idle),  32'(m_owner == 0 && !m_turn));
    check("hold_cnt",  32'(hold_cnt),  32'(m_hold));
    check("cpu_yield", 32'(cpu_yield), 32'(eg_cpu && acc_req && m_hold >= int'(MAX_HOLD)));
    check("acc_yield", 32'(acc_yield), 32'(eg_acc && cpu_req && m_hold >= int'(MAX_HOLD)));
  endtask

  task automatic step(input logic c, input logic a);
    cpu_req = c; acc_req = a;
    @(posedge clk);
    model_step(c, a);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    cpu_req = 1'b0; acc_req = 1'b0; rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic c, a;
    model_reset();

    // T1: single CPU request, one-cycle latency, counting hold
    do_reset();
    step(0, 0);
    step(1, 0);
    check("t1_gnt", 32'(cpu_gnt), 32'd1);
    check("t1_idle", 32'(bus_idle), 32'd0);
    step(1, 0);
    step(1, 0);
    check("t1_hold3", 32'(hold_cnt), 32'd3);

    // T2: simultaneous requests, CPU first after reset, then TURN, then ACC
    do_reset();
    step(1, 1);
    check("t2_cpu_first", 32'(cpu_gnt), 32'd1);
    step(1, 1); step(1, 1);
    step(0, 1);
    check("t2_turn", 32'({cpu_gnt, acc_gnt, bus_idle}), 32'd0);
    step(0, 1);
    check("t2_acc", 32'({acc_gnt, arb_res}), 32'd3);

    // T3: long CPU hold with ACC waiting -> yield, saturation, handover
    do_reset();
    for (int i = 1; i <= 35; i++) begin
      step(1, i >= 3);
      if (i == 15) check("t3_no_yield15", 32'(cpu_yield), 32'd0);
      if (i == 16) check("t3_yield16", 32'(cpu_yield), 32'd1);
    end
    check("t3_sat", 32'(hold_cnt), 32'(SAT));
    step(0, 1);
    check("t3_yield_off", 32'(cpu_yield), 32'd0);
    step(0, 1);
    check("t3_acc", 32'(acc_gnt), 32'd1);

    // T4: ACC request withdrawn during TURN -> IDLE without grant
    do_reset();
    step(1, 0); step(1, 0);
    step(0, 1);
    step(0, 0);
    check("t4_idle", 32'({acc_gnt, bus_idle}), 32'd1);

    // T5: async reset while ACC holds with hold_cnt 7
    do_reset();
    for (int i = 0; i < 7; i++) step(0, 1);
    check("t5_hold7", 32'(hold_cnt), 32'd7);
    do_reset();
    check("t5_rst", 32'({acc_gnt, arb_res, hold_cnt}), 32'd0);
    step(1, 1);
    check("t5_cpu_first", 32'(cpu_gnt), 32'd1);

    // T6: alternating ownership with re-requests
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) step(1, 1);
      check("t6_owner", 32'(acc_gnt), 32'(k % 2));
      if (k % 2 == 0) step(0, 1); else step(1, 0);
      check("t6_turn", 32'({cpu_gnt, acc_gnt, bus_idle}), 32'd0);
    end

    // Randomized traffic with long and short holds
    do_reset();
    c = 1'b0; a = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (c) c = ($urandom_range(23) != 0); else c = ($urandom_range(3) == 0);
      if (a) a = ($urandom_range(23) != 0); else a = ($urandom_range(3) == 0);
      step(c, a);
      if ($urandom_range(499) == 0) begin
        do_reset();
        c = 1'b0; a = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
